// File: rtl/poco_mem_arb.sv
// Arbitrates one single-port RAM among host, data and instruction ports (host > data > instr, with a starvation guard for the CPU ports).
// Grant is combinational and read data returns one cycle after grant; optional round-robin d/i arbitration when MEMARB_RR_EN is defined.
module poco_mem_arb #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2,
        TAG_H    = 2'd3
    } tag_e;

    tag_e            tag_q, tag_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic            cpu_req;
    logic            guard;
    logic            d_wins;

`ifdef MEMARB_RR_EN
    // Set when data won the most recent d/i grant; reset favours data on the first tie.
    logic last_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (d_gnt || i_gnt) begin
            last_d_q <= d_gnt;
        end
    end

    assign d_wins = d_req && (!i_req || !last_d_q);
`else
    assign d_wins = d_req;
`endif

    assign cpu_req = d_req || i_req;
    assign guard   = (sc_q == SC_W'(STARVE_MAX)) && cpu_req;

    // Grants are forced low while reset is asserted so the RAM sees no access.
    always_comb begin
        h_gnt = 1'b0;
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (rst_n) begin
            if (h_req && !guard) begin
                h_gnt = 1'b1;
            end else if (d_wins) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        m_en    = h_gnt || d_gnt || i_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        tag_d   = TAG_NONE;
        if (h_gnt) begin
            m_we    = h_we;
            m_addr  = h_addr;
            m_wdata = h_wdata;
            tag_d   = h_we ? TAG_NONE : TAG_H;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            tag_d   = d_we ? TAG_NONE : TAG_D;
        end else if (i_gnt) begin
            m_addr  = i_addr;
            tag_d   = TAG_I;
        end
    end

    // Counts host wins while a CPU port waits; any CPU win or idle CPU clears it.
    always_comb begin
        sc_d = sc_q;
        if (!cpu_req || d_gnt || i_gnt) begin
            sc_d = '0;
        end else if (h_gnt) begin
            sc_d = sc_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= TAG_NONE;
            sc_q  <= '0;
        end else begin
            tag_q <= tag_d;
            sc_q  <= sc_d;
        end
    end

    assign h_rvalid = rst_n && (tag_q == TAG_H);
    assign d_rvalid = rst_n && (tag_q == TAG_D);
    assign i_rvalid = rst_n && (tag_q == TAG_I);
    assign h_rdata  = rst_n ? m_rdata : '0;
    assign d_rdata  = rst_n ? m_rdata : '0;
    assign i_rdata  = rst_n ? m_rdata : '0;

endmodule

// File: tb/tb_poco_mem_arb.sv
// Directed bench for poco_mem_arb: table-driven single-cycle vectors plus starvation, tie, reset and idle sequences.
module tb_poco_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, h_req, d_we, h_we;
    logic [15:0] i_addr, d_addr, h_addr, d_wdata, h_wdata;
    logic        i_gnt, d_gnt, h_gnt, i_rvalid, d_rvalid, h_rvalid;
    logic [15:0] i_rdata, d_rdata, h_rdata;
    logic        m_en, m_we;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata = 16'h0;
    logic [15:0] mem [0:255];

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    poco_mem_arb #(.DATA_W(16), .ADDR_W(16), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Synchronous RAM model: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr[7:0]] <= m_wdata;
            else      m_rdata <= mem[m_addr[7:0]];
        end
    end

    typedef struct {
        logic [2:0]  req;   // {h,d,i}
        logic        hwe;
        logic [15:0] haddr, hwd;
        logic        dwe;
        logic [15:0] daddr, dwd, iaddr;
        logic [2:0]  gnt;   // expected {h,d,i}
        logic        we;
        logic [15:0] addr, wd;
        logic [2:0]  rv;    // expected {h,d,i} rvalid
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic [2:0] r, input logic hw, input logic [15:0] ha, input logic [15:0] hd,
                         input logic dw, input logic [15:0] da, input logic [15:0] dd, input logic [15:0] ia);
        {h_req, d_req, i_req} = r;
        h_we = hw; h_addr = ha; h_wdata = hd;
        d_we = dw; d_addr = da; d_wdata = dd;
        i_addr = ia;
    endtask

    function automatic logic [39:0] outs();
        return {h_gnt, d_gnt, i_gnt, m_en, m_we, m_addr, m_wdata, h_rvalid, d_rvalid, i_rvalid};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                req     hwe haddr    hwd      dwe daddr    dwd      iaddr    gnt     we addr     wd       rv      rdata
        vecs[0]  = '{3'b000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0, 16'h0000, 16'h0000, 3'b000, 16'h0000};
        vecs[1]  = '{3'b100, 1, 16'h0010, 16'h1234, 0, 16'h0000, 16'h0000, 16'h0000, 3'b100, 1, 16'h0010, 16'h1234, 3'b000, 16'h0000};
        vecs[2]  = '{3'b100, 1, 16'h0002, 16'h5555, 0, 16'h0000, 16'h0000, 16'h0000, 3'b100, 1, 16'h0002, 16'h5555, 3'b000, 16'h0000};
        vecs[3]  = '{3'b001, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0010, 3'b001, 0, 16'h0010, 16'h0000, 3'b000, 16'h0000};
        vecs[4]  = '{3'b000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0, 16'h0000, 16'h0000, 3'b001, 16'h1234};
        vecs[5]  = '{3'b011, 0, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0000, 16'h0010, 3'b010, 0, 16'h0002, 16'h0000, 3'b000, 16'h0000};
        vecs[6]  = '{3'b001, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0010, 3'b001, 0, 16'h0010, 16'h0000, 3'b010, 16'h5555};
        vecs[7]  = '{3'b010, 0, 16'h0000, 16'h0000, 1, 16'h0020, 16'hBEEF, 16'h0000, 3'b010, 1, 16'h0020, 16'hBEEF, 3'b001, 16'h1234};
        vecs[8]  = '{3'b001, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0020, 3'b001, 0, 16'h0020, 16'h0000, 3'b000, 16'h0000};
        vecs[9]  = '{3'b000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0, 16'h0000, 16'h0000, 3'b001, 16'hBEEF};
        vecs[10] = '{3'b111, 0, 16'h0002, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0010, 3'b100, 0, 16'h0002, 16'h0000, 3'b000, 16'h0000};
        vecs[11] = '{3'b000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0, 16'h0000, 16'h0000, 3'b100, 16'h5555};
        vecs[12] = '{3'b000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0, 16'h0000, 16'h0000, 3'b000, 16'h0000};

        // Reset with a request pending: outputs must stay low.
        rst_n = 1'b0;
        drive(3'b001, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0010);
        #1;
        chk("reset_outputs", {24'h0, outs()}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        drive(3'b000, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            drive(vecs[k].req, vecs[k].hwe, vecs[k].haddr, vecs[k].hwd,
                  vecs[k].dwe, vecs[k].daddr, vecs[k].dwd, vecs[k].iaddr);
            #1;
            chk($sformatf("vec%0d_outs", k), {24'h0, outs()},
                {24'h0, vecs[k].gnt, |vecs[k].gnt, vecs[k].we, vecs[k].addr, vecs[k].wd, vecs[k].rv});
            case (vecs[k].rv)
                3'b100: chk($sformatf("vec%0d_h_rdata", k), {48'h0, h_rdata}, {48'h0, vecs[k].rdata});
                3'b010: chk($sformatf("vec%0d_d_rdata", k), {48'h0, d_rdata}, {48'h0, vecs[k].rdata});
                3'b001: chk($sformatf("vec%0d_i_rdata", k), {48'h0, i_rdata}, {48'h0, vecs[k].rdata});
                default: ;
            endcase
        end

        // Starvation guard: four host grants, then data, then host again.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(3'b110, 1, 16'h0030, 16'h0001, 0, 16'h0002, 16'h0000, 16'h0000);
            #1;
            chk($sformatf("starve_c%0d_gnt", k), {61'h0, h_gnt, d_gnt, i_gnt},
                {61'h0, (k == 4) ? 3'b010 : 3'b100});
            if (k == 5) begin
                chk("starve_d_rvalid", {61'h0, h_rvalid, d_rvalid, i_rvalid}, 64'h2);
                chk("starve_d_rdata", {48'h0, d_rdata}, {48'h0, 16'h5555});
            end
        end

        // One instr grant so the tie sequence starts with data favoured.
        @(negedge clk);
        drive(3'b001, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0010);
        #1;
        chk("pre_tie_i_gnt", {63'h0, i_gnt}, 64'h1);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(3'b011, 0, 16'h0, 16'h0, 0, 16'h0002, 16'h0, 16'h0010);
            #1;
`ifdef MEMARB_RR_EN
            chk($sformatf("tie_c%0d_gnt", k), {61'h0, h_gnt, d_gnt, i_gnt},
                {61'h0, (k % 2 == 0) ? 3'b010 : 3'b001});
`else
            chk($sformatf("tie_c%0d_gnt", k), {61'h0, h_gnt, d_gnt, i_gnt}, {61'h0, 3'b010});
`endif
        end

        // Reset right after a host read grant discards the return.
        @(negedge clk);
        drive(3'b100, 0, 16'h0010, 16'h0, 0, 16'h0, 16'h0, 16'h0);
        #1;
        chk("rst_h_gnt", {63'h0, h_gnt}, 64'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {24'h0, outs()}, 64'h0);
        @(negedge clk);
        chk("rst_held_outs", {24'h0, outs()}, 64'h0);
        drive(3'b001, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0010);
        rst_n = 1'b1;
        #1;
        chk("post_rst_i_gnt", {24'h0, outs()}, {24'h0, 3'b001, 1'b1, 1'b0, 16'h0010, 16'h0000, 3'b000});
        @(negedge clk);
        drive(3'b000, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 16'h0);
        #1;
        chk("post_rst_rvalid", {61'h0, h_rvalid, d_rvalid, i_rvalid}, 64'h1);
        chk("post_rst_i_rdata", {48'h0, i_rdata}, {48'h0, 16'h1234});

        // Idle: no access and no return for ten cycles.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle_c%0d", k), {24'h0, outs()}, 64'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
